// File: rtl/sram_pkg.sv
// Shared types and helpers for the multi-bank coefficient SRAM.
// The parity helper is used only when SRAM_PARITY_EN is defined.
package sram_pkg;

  typedef enum logic [1:0] {
    CLEAR = 2'd0,
    IDLE  = 2'd1,
    LOAD  = 2'd2
  } sram_state_t;

  // Widest data word the parity helper covers; narrower words are zero-extended.
  localparam int unsigned PAR_MAXW = 64;

  function automatic int unsigned addr_w(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  function automatic int unsigned caddr_w(input int unsigned nbank, input int unsigned depth);
    return $clog2(nbank) + addr_w(depth);
  endfunction

  function automatic logic even_par(input logic [PAR_MAXW-1:0] data);
    return ^data;
  endfunction

endpackage

// File: rtl/sram_bank.sv
// One DEPTH x WIDTH bank: single write port, registered read port, write-to-read forwarding.
// With SRAM_PARITY_EN defined each word carries an even-parity bit checked on read.
module sram_bank
  import sram_pkg::*;
#(
  parameter int unsigned DEPTH = 256,
  parameter int unsigned WIDTH = 20
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      we_i,
  input  logic [addr_w(DEPTH)-1:0]  waddr_i,
  input  logic [WIDTH-1:0]          wdata_i,
  input  logic                      winj_i,
  input  logic                      re_i,
  input  logic [addr_w(DEPTH)-1:0]  raddr_i,
  output logic [WIDTH-1:0]          q_o,
  output logic                      perr_o
);

  logic [WIDTH-1:0] q_q, q_d;
  logic             perr_q, perr_d;
  logic             fwd;

  assign fwd = we_i && (waddr_i == raddr_i);

`ifdef SRAM_PARITY_EN
  logic [WIDTH:0] mem_q [DEPTH];
  logic [WIDTH:0] wword;
  logic [WIDTH:0] rword;

  assign wword = {even_par(PAR_MAXW'(wdata_i)) ^ winj_i, wdata_i};

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wword;
  end

  always_comb begin
    rword  = fwd ? wword : mem_q[raddr_i];
    q_d    = rword[WIDTH-1:0];
    perr_d = rword[WIDTH] ^ even_par(PAR_MAXW'(rword[WIDTH-1:0]));
  end
`else
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             unused_inj;

  assign unused_inj = winj_i;

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  always_comb begin
    q_d    = fwd ? wdata_i : mem_q[raddr_i];
    perr_d = 1'b0;
  end
`endif

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      q_q    <= '0;
      perr_q <= 1'b0;
    end else if (re_i) begin
      q_q    <= q_d;
      perr_q <= perr_d;
    end
  end

  assign q_o    = q_q;
  assign perr_o = perr_q;

endmodule

// File: rtl/sram_nbank.sv
// NBANK-bank coefficient SRAM: parallel registered reads, shared write port,
// post-reset clear sweep and streaming linear load. Optional parity: SRAM_PARITY_EN.
module sram_nbank
  import sram_pkg::*;
#(
  parameter int unsigned NBANK = 8,
  parameter int unsigned DEPTH = 256,
  parameter int unsigned WIDTH = 20
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                CEN,
  input  logic                                WEN,
  input  logic [caddr_w(NBANK, DEPTH)-1:0]    CADDR,
  input  logic [WIDTH-1:0]                    D,
  input  logic [NBANK*addr_w(DEPTH)-1:0]      A,
  output logic [NBANK*WIDTH-1:0]              Q,
  input  logic                                ld_start,
  input  logic                                ld_valid,
  input  logic [WIDTH-1:0]                    ld_data,
  output logic                                ld_ready,
  output logic                                ld_done,
  output logic                                init_done,
  input  logic                                par_inj,
  output logic [NBANK-1:0]                    par_err
);

  localparam int unsigned AW = addr_w(DEPTH);
  localparam int unsigned CW = caddr_w(NBANK, DEPTH);
  localparam int unsigned BW = CW - AW;

  sram_state_t   state_q, state_d;
  logic [AW-1:0] clr_addr_q, clr_addr_d;
  logic [CW-1:0] ld_addr_q, ld_addr_d;
  logic          ld_ready_q, ld_ready_d;
  logic          ld_done_q, ld_done_d;
  logic          init_done_q, init_done_d;

  logic             clr_we, ld_we, dir_we, sel_we, rd_en;
  logic [AW-1:0]    wr_addr;
  logic [BW-1:0]    wr_bank;
  logic [WIDTH-1:0] wr_data;
  logic             wr_inj;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= CLEAR;
      clr_addr_q  <= '0;
      ld_addr_q   <= '0;
      ld_ready_q  <= 1'b0;
      ld_done_q   <= 1'b0;
      init_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      clr_addr_q  <= clr_addr_d;
      ld_addr_q   <= ld_addr_d;
      ld_ready_q  <= ld_ready_d;
      ld_done_q   <= ld_done_d;
      init_done_q <= init_done_d;
    end
  end

  // Write strobes are gated by rst_n so a reset edge never disturbs memory contents.
  always_comb begin
    state_d    = state_q;
    clr_addr_d = clr_addr_q;
    ld_addr_d  = ld_addr_q;
    ld_done_d  = 1'b0;
    clr_we     = 1'b0;
    ld_we      = 1'b0;
    dir_we     = 1'b0;
    if (rst_n) begin
      case (state_q)
        CLEAR: begin
          clr_we     = 1'b1;
          clr_addr_d = clr_addr_q + 1'b1;
          if (clr_addr_q == AW'(DEPTH - 1)) state_d = IDLE;
        end
        IDLE: begin
          dir_we = !CEN && !WEN;
          if (ld_start) begin
            state_d   = LOAD;
            ld_addr_d = '0;
          end
        end
        LOAD: begin
          if (ld_valid && ld_ready_q) begin
            ld_we     = 1'b1;
            ld_addr_d = ld_addr_q + 1'b1;
            if (ld_addr_q == CW'(NBANK * DEPTH - 1)) begin
              state_d   = IDLE;
              ld_done_d = 1'b1;
            end
          end
        end
        default: state_d = CLEAR;
      endcase
    end
    ld_ready_d  = (state_d == LOAD);
    init_done_d = init_done_q || (state_q != CLEAR);
  end

  always_comb begin
    wr_addr = CADDR[AW-1:0];
    wr_bank = CADDR[CW-1:AW];
    wr_data = D;
    wr_inj  = par_inj;
    if (clr_we) begin
      wr_addr = clr_addr_q;
      wr_data = '0;
      wr_inj  = 1'b0;
    end else if (ld_we) begin
      wr_addr = ld_addr_q[AW-1:0];
      wr_bank = ld_addr_q[CW-1:AW];
      wr_data = ld_data;
      wr_inj  = 1'b0;
    end
  end

  assign sel_we = ld_we || dir_we;
  assign rd_en  = !CEN && (state_q != CLEAR);

  for (genvar b = 0; b < NBANK; b++) begin : g_bank
    logic bank_we;
    assign bank_we = clr_we || (sel_we && (wr_bank == BW'(b)));

    sram_bank #(
      .DEPTH (DEPTH),
      .WIDTH (WIDTH)
    ) u_bank (
      .clk_i   (clk),
      .rst_ni  (rst_n),
      .we_i    (bank_we),
      .waddr_i (wr_addr),
      .wdata_i (wr_data),
      .winj_i  (wr_inj),
      .re_i    (rd_en),
      .raddr_i (A[b*AW +: AW]),
      .q_o     (Q[b*WIDTH +: WIDTH]),
      .perr_o  (par_err[b])
    );
  end

  assign ld_ready  = ld_ready_q;
  assign ld_done   = ld_done_q;
  assign init_done = init_done_q;

endmodule
